// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - MEM/WB stage signal bundle: MEM capture, register file write port, decode bypass
//
// Signals:
//   stall, flush                 pipeline control into the stage
//   mem_*                        instruction leaving MEM
//   write_en/addr/value          register file write port
//   id_rs*_addr / id_rs*_raw     decode-stage read indices and register file data
//   id_rs*_data                  bypassed decode operands
//   retire_count                 retired valid instruction count
// Modports: master drives the pipeline inputs, slave is the stage itself.
interface mem_wb_stage_if;
    logic        stall;
    logic        flush;
    logic        mem_valid;
    logic        mem_reg_write;
    logic [4:0]  mem_rd_addr;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_load_data;
    logic [31:0] mem_pc_plus4;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [31:0] write_value;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic [31:0] id_rs1_raw;
    logic [31:0] id_rs2_raw;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] retire_count;

    modport master (
        output stall, flush, mem_valid, mem_reg_write, mem_rd_addr, mem_wb_sel,
               mem_funct3, mem_alu_result, mem_load_data, mem_pc_plus4,
               id_rs1_addr, id_rs2_addr, id_rs1_raw, id_rs2_raw,
        input  write_en, write_addr, write_value, id_rs1_data, id_rs2_data, retire_count
    );

    modport slave (
        input  stall, flush, mem_valid, mem_reg_write, mem_rd_addr, mem_wb_sel,
               mem_funct3, mem_alu_result, mem_load_data, mem_pc_plus4,
               id_rs1_addr, id_rs2_addr, id_rs1_raw, id_rs2_raw,
        output write_en, write_addr, write_value, id_rs1_data, id_rs2_data, retire_count
    );
endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - RV32I MEM/WB pipeline register, load extension, writeback select, decode bypass
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      mem_wb_stage_if.slave (MEM inputs, register file write port, decode bypass, retire count)
module mem_wb_stage (
    input  logic           clk,
    input  logic           reset_n,
    mem_wb_stage_if.slave  bus
);

    logic        valid_q,     valid_d;
    logic        reg_write_q, reg_write_d;
    logic [4:0]  rd_q,        rd_d;
    logic [1:0]  wb_sel_q,    wb_sel_d;
    logic [2:0]  funct3_q,    funct3_d;
    logic [31:0] alu_q,       alu_d;
    logic [31:0] load_q,      load_d;
    logic [31:0] pc4_q,       pc4_d;
    logic [31:0] retire_q,    retire_d;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] wb_value;
    logic        wb_en;

    // Flush only needs to kill the side effects; the payload fields are
    // don't-care for a bubble, so they simply hold.
    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        rd_d        = rd_q;
        wb_sel_d    = wb_sel_q;
        funct3_d    = funct3_q;
        alu_d       = alu_q;
        load_d      = load_q;
        pc4_d       = pc4_q;
        if (bus.flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end else if (!bus.stall) begin
            valid_d     = bus.mem_valid;
            reg_write_d = bus.mem_reg_write;
            rd_d        = bus.mem_rd_addr;
            wb_sel_d    = bus.mem_wb_sel;
            funct3_d    = bus.mem_funct3;
            alu_d       = bus.mem_alu_result;
            load_d      = bus.mem_load_data;
            pc4_d       = bus.mem_pc_plus4;
        end
    end

    // An instruction retires on the edge it leaves WB: either advanced
    // normally or pushed out by a flush (flush beats stall).
    always_comb begin
        retire_d = retire_q;
        if (valid_q && (!bus.stall || bus.flush)) begin
            retire_d = retire_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= 5'd0;
            wb_sel_q    <= 2'b00;
            funct3_q    <= 3'b000;
            alu_q       <= 32'd0;
            load_q      <= 32'd0;
            pc4_q       <= 32'd0;
            retire_q    <= 32'd0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            wb_sel_q    <= wb_sel_d;
            funct3_q    <= funct3_d;
            alu_q       <= alu_d;
            load_q      <= load_d;
            pc4_q       <= pc4_d;
            retire_q    <= retire_d;
        end
    end

    // Byte lane from the low address bits; halfword uses only bit 1.
    always_comb begin
        ld_byte = load_q[{alu_q[1:0], 3'b000} +: 8];
        ld_half = alu_q[1] ? load_q[31:16] : load_q[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'd0, ld_half};
            3'b010:  ld_ext = load_q;
            default: ld_ext = 32'd0;
        endcase
    end

    always_comb begin
        case (wb_sel_q)
            2'b00:   wb_value = alu_q;
            2'b01:   wb_value = ld_ext;
            2'b10:   wb_value = pc4_q;
            default: wb_value = 32'd0;
        endcase
    end

    // x0 is filtered by the register file, not here; the bypass must still
    // never forward into x0 reads.
    assign wb_en            = valid_q & reg_write_q;
    assign bus.write_en     = wb_en;
    assign bus.write_addr   = rd_q;
    assign bus.write_value  = wb_value;
    assign bus.retire_count = retire_q;

    assign bus.id_rs1_data = (wb_en && (rd_q == bus.id_rs1_addr) && (bus.id_rs1_addr != 5'd0))
                             ? wb_value : bus.id_rs1_raw;
    assign bus.id_rs2_data = (wb_en && (rd_q == bus.id_rs2_addr) && (bus.id_rs2_addr != 5'd0))
                             ? wb_value : bus.id_rs2_raw;

endmodule
